// File: rtl/cpu_types_pkg.sv
// Shared pipeline-control types: controller states, register ids, latch control bundle.
package cpu_types_pkg;

  localparam int unsigned REG_W = 5;

  typedef logic [REG_W-1:0] regbits_t;

  typedef enum logic [1:0] {
    RUN    = 2'd0,
    DWAIT  = 2'd1,
    HALTED = 2'd2
  } ctrl_state_t;

  // Enable/flush pairs for the four pipeline latches plus the PC enable.
  typedef struct packed {
    logic pc_en;
    logic ifid_en;
    logic ifid_flush;
    logic idex_en;
    logic idex_flush;
    logic exmem_en;
    logic exmem_flush;
    logic memwb_en;
    logic memwb_flush;
  } hazard_t;

endpackage

// File: rtl/pipeline_ctrl_if.sv
// Hazard inputs from the datapath and latch controls / status back to it.
interface pipeline_ctrl_if
  import cpu_types_pkg::*;
#(
  parameter int unsigned CNT_W = 32
) ();

  logic             ihit;
  logic             dhit;
  logic             exmem_dREN;
  logic             exmem_dWEN;
  logic             exmem_halt;
  logic             redirect;
  logic             idex_dREN;
  regbits_t         idex_wsel;
  regbits_t         ifid_rs;
  regbits_t         ifid_rt;

  logic             pc_en;
  logic             ifid_en;
  logic             idex_en;
  logic             exmem_en;
  logic             memwb_en;
  logic             ifid_flush;
  logic             idex_flush;
  logic             exmem_flush;
  logic             memwb_flush;
  logic             halt;
  logic             err_timeout;
  logic [CNT_W-1:0] stall_cnt;

  modport master (
    input  ihit, dhit, exmem_dREN, exmem_dWEN, exmem_halt, redirect,
           idex_dREN, idex_wsel, ifid_rs, ifid_rt,
    output pc_en, ifid_en, idex_en, exmem_en, memwb_en,
           ifid_flush, idex_flush, exmem_flush, memwb_flush,
           halt, err_timeout, stall_cnt
  );

  modport slave (
    output ihit, dhit, exmem_dREN, exmem_dWEN, exmem_halt, redirect,
           idex_dREN, idex_wsel, ifid_rs, ifid_rt,
    input  pc_en, ifid_en, idex_en, exmem_en, memwb_en,
           ifid_flush, idex_flush, exmem_flush, memwb_flush,
           halt, err_timeout, stall_cnt
  );

endinterface

// File: rtl/hazard_detect.sv
// Load-use comparator: load in EX writes a register the ID instruction reads.
module hazard_detect
  import cpu_types_pkg::*;
(
  input  logic     idex_dREN,
  input  regbits_t idex_wsel,
  input  regbits_t ifid_rs,
  input  regbits_t ifid_rt,
  output logic     lu_hazard
);

  // r0 is hardwired zero, so a load targeting it never creates a dependency.
  assign lu_hazard = idex_dREN && (idex_wsel != '0) &&
                     ((idex_wsel == ifid_rs) || (idex_wsel == ifid_rt));

endmodule

// File: rtl/pipeline_ctrl.sv
// Stall/flush sequencer for the five-stage pipeline with halt latch and stall statistics.
module pipeline_ctrl
  import cpu_types_pkg::*;
#(
  parameter int unsigned DWAIT_MAX = 255,
  parameter int unsigned CNT_W     = 32
) (
  input  logic CLK,
  input  logic RST,
  pipeline_ctrl_if.master bus
);

  localparam int unsigned DW_BITS = $clog2(DWAIT_MAX + 1);
  localparam int unsigned WAIT_W  = (DW_BITS > 8) ? DW_BITS : 8;

  ctrl_state_t      state;
  ctrl_state_t      state_next;
  hazard_t          hz;
  logic             mem_req;
  logic             mem_freeze;
  logic             lu_hazard;
  logic [WAIT_W-1:0] wait_cnt;
  logic             halt_r;
  logic             err_r;
  logic [CNT_W-1:0] stall_r;

  assign mem_req    = bus.exmem_dREN | bus.exmem_dWEN;
  assign mem_freeze = mem_req & ~bus.dhit;

  hazard_detect u_hazard_detect (
    .idex_dREN (bus.idex_dREN),
    .idex_wsel (bus.idex_wsel),
    .ifid_rs   (bus.ifid_rs),
    .ifid_rt   (bus.ifid_rt),
    .lu_hazard (lu_hazard)
  );

  // Next state and prioritized latch controls, all from current state and inputs.
  always_comb begin
    state_next = state;
    hz         = '0;

    case (state)
      RUN: begin
        if (bus.exmem_halt && !mem_freeze) state_next = HALTED;
        else if (mem_freeze)               state_next = DWAIT;
      end
      DWAIT: begin
        if (bus.exmem_halt && !mem_freeze) state_next = HALTED;
        else if (bus.dhit)                 state_next = RUN;
      end
      HALTED:  state_next = HALTED;
      default: state_next = RUN;
    endcase

    if (RST || (state == HALTED) || mem_freeze) begin
      hz = '0;
    end else if (bus.redirect) begin
      // Squash everything younger than MEM; the redirect target is fetched next.
      hz.pc_en       = 1'b1;
      hz.ifid_flush  = 1'b1;
      hz.idex_flush  = 1'b1;
      hz.exmem_flush = 1'b1;
      hz.memwb_en    = 1'b1;
    end else if (lu_hazard) begin
      // Hold PC and IF/ID, drop a bubble into EX while the load moves on.
      hz.idex_flush = 1'b1;
      hz.exmem_en   = 1'b1;
      hz.memwb_en   = 1'b1;
    end else if (!bus.ihit) begin
      hz.ifid_flush = 1'b1;
      hz.idex_en    = 1'b1;
      hz.exmem_en   = 1'b1;
      hz.memwb_en   = 1'b1;
    end else begin
      hz.pc_en    = 1'b1;
      hz.ifid_en  = 1'b1;
      hz.idex_en  = 1'b1;
      hz.exmem_en = 1'b1;
      hz.memwb_en = 1'b1;
    end
  end

  // Controller state register.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) state <= RUN;
    else     state <= state_next;
  end

  // Data-access wait counter, restarted on each entry into DWAIT.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      wait_cnt <= '0;
    end else if ((state == RUN) && (state_next == DWAIT)) begin
      wait_cnt <= '0;
    end else if ((state == DWAIT) && (wait_cnt != '1)) begin
      wait_cnt <= wait_cnt + WAIT_W'(1);
    end
  end

  // Sticky status flags: halt and data-access timeout.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      halt_r <= 1'b0;
      err_r  <= 1'b0;
    end else begin
      if (state_next == HALTED) halt_r <= 1'b1;
      if ((state == DWAIT) && mem_freeze && (wait_cnt == WAIT_W'(DWAIT_MAX))) err_r <= 1'b1;
    end
  end

  // Saturating count of cycles the PC was held while not halted.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      stall_r <= '0;
    end else if ((state != HALTED) && !hz.pc_en && (stall_r != '1)) begin
      stall_r <= stall_r + CNT_W'(1);
    end
  end

  assign bus.pc_en       = hz.pc_en;
  assign bus.ifid_en     = hz.ifid_en;
  assign bus.ifid_flush  = hz.ifid_flush;
  assign bus.idex_en     = hz.idex_en;
  assign bus.idex_flush  = hz.idex_flush;
  assign bus.exmem_en    = hz.exmem_en;
  assign bus.exmem_flush = hz.exmem_flush;
  assign bus.memwb_en    = hz.memwb_en;
  assign bus.memwb_flush = hz.memwb_flush;
  assign bus.halt        = halt_r;
  assign bus.err_timeout = err_r;
  assign bus.stall_cnt   = stall_r;

endmodule

// File: doc/pipeline_ctrl.md
# pipeline_ctrl

Hazard and stall sequencer for the five-stage pipeline. It generates the enable/flush pair for each of the four pipeline latches (IF/ID, ID/EX, EX/MEM, MEM/WB) and the PC enable. It freezes the pipeline on outstanding data-memory accesses, inserts bubbles for instruction-fetch misses and load-use hazards, and squashes younger stages on a taken branch/jump resolved in MEM. It also latches the halt condition and keeps stall/timeout statistics.

## Interface
Parameters:
- DWAIT_MAX, 255, DWAIT cycles before err_timeout sets
- CNT_W, 32, width of stall_cnt

Ports:
- CLK  in  1  pipeline clock
- RST  in  1  asynchronous, active-high reset
- ihit  in  1  instruction fetch complete this cycle
- dhit  in  1  data access complete this cycle
- exmem_dREN  in  1  load in MEM stage
- exmem_dWEN  in  1  store in MEM stage
- exmem_halt  in  1  halt instruction in MEM stage
- redirect  in  1  taken branch/jump resolved in MEM (PCsrc != sequential)
- idex_dREN  in  1  load in EX stage
- idex_wsel  in  5  load destination in EX (regbits_t)
- ifid_rs, ifid_rt  in  5 each  source registers of instruction in ID
- pc_en  out  1  PC may update
- ifid_en, idex_en, exmem_en, memwb_en  out  1 each  latch advance
- ifid_flush, idex_flush, exmem_flush, memwb_flush  out  1 each  latch loads bubble (priority over en inside the latch)
- halt  out  1  sticky, processor halted
- err_timeout  out  1  sticky, data access exceeded DWAIT_MAX
- stall_cnt  out  CNT_W  saturating count of stall cycles

## Operation
- State machine: RUN, DWAIT, HALTED (ctrl_state_t).
- mem_req = exmem_dREN | exmem_dWEN; mem_freeze = mem_req & ~dhit.
- Condition priority, highest first:
  1. HALTED: all en 0, all flush 0, pc_en 0.
  2. mem_freeze: all en 0, pc_en 0, no flush.
  3. redirect: pc_en 1; ifid/idex/exmem flush 1; memwb_en 1.
  4. load-use: idex_dREN & idex_wsel != 0 & (idex_wsel == ifid_rs | idex_wsel == ifid_rt). Effect: pc_en 0, ifid_en 0, idex_flush 1, exmem_en and memwb_en 1.
  5. ~ihit: pc_en 0, ifid_flush 1, later latches en 1.
  6. Otherwise: all en 1, pc_en 1, no flush.
- Transitions:
  - RUN -> DWAIT on mem_freeze.
  - DWAIT -> RUN on dhit.
  - RUN/DWAIT -> HALTED when exmem_halt & ~mem_freeze, so the halt instruction advances into MEM/WB that edge.
  - HALTED holds until reset.
- wait_cnt (8 bits min, sized for DWAIT_MAX):
  - Cleared on entry to DWAIT; increments each DWAIT cycle.
  - err_timeout sets when wait_cnt == DWAIT_MAX while still waiting. The FSM keeps waiting.
- stall_cnt increments on any cycle where pc_en == 0 and state != HALTED. Saturates at all-ones.
- Simultaneous redirect and load-use: redirect wins (the hazard instruction is squashed).
- ~ihit during redirect: redirect wins; the next cycle resolves the fetch.

## Timing
- All enables/flushes are combinational from state and current inputs, valid in the same cycle. No added latency.
- State, wait_cnt, stall_cnt, halt and err_timeout are registered on the rising edge of CLK.
- dhit in the same cycle as mem_req: zero stall, DWAIT not entered.
- Reset (async, any time, including mid-DWAIT):
  - state RUN, wait_cnt 0, stall_cnt 0, halt 0, err_timeout 0.
  - While RST is high: all en 0, all flush 0, pc_en 0.
- Release from DWAIT: the dhit cycle has all en 1 (or the lower-priority result), and the state is RUN next cycle.
- halt rises the cycle after the HALTED transition edge, together with state == HALTED.

## Structure
- cpu_types_pkg holds:
  - ctrl_state_t enum (RUN, DWAIT, HALTED)
  - regbits_t, reused for idex_wsel/ifid_rs/ifid_rt
  - a hazard_t packed struct grouping the four en/flush pairs plus pc_en, used by the top-level connection to the latch interfaces
- One sub-module, hazard_detect: purely combinational load-use comparator. Outputs lu_hazard.
- The FSM and counters stay in pipeline_ctrl.

## Test plan
- Load with dhit delayed 3 cycles:
  - Required: all en 0 for 3 cycles, then advance on the dhit cycle.
  - Required: state RUN → DWAIT → RUN; stall_cnt = 3.
- Load r5 in EX, ID reads rs = 5:
  - Required: one cycle of pc_en 0, ifid_en 0, idex_flush 1.
  - Same stimulus with wsel = 0: no stall.
- Redirect asserted together with a load-use hazard: pc_en 1, flush ifid/idex/exmem, memwb_en 1, stall_cnt unchanged.
- exmem_halt with dhit 1: HALTED next cycle, halt 1, all outputs 0. Holds for 10 cycles, cleared only by RST.
- Store with dhit held low for DWAIT_MAX + 2 cycles:
  - Required: err_timeout 1 after DWAIT_MAX cycles; pipeline stays frozen.
  - Asserting RST mid-wait clears all state asynchronously.
- ihit low for 2 cycles, no other hazard: pc_en 0 and ifid_flush 1 for 2 cycles, later latches advance, stall_cnt += 2.
